// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM driver command/write-data channel between the framebuffer writer and the
// display prefetch reader. Reads win, except that a waiting write is granted after RD_STREAK_MAX reads.
module sdram_port_arbiter #(
  parameter int ADDR_WIDTH    = 24,
  parameter int DATA_WIDTH    = 16,
  parameter int BURST_LEN     = 8,
  parameter int RD_STREAK_MAX = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_valid_i,
  output logic                  rd_ready_o,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic                  cmd_valid_o,
  input  logic                  cmd_ready_i,
  output logic                  cmd_write_o,
  output logic [ADDR_WIDTH-1:0] cmd_addr_o,
  output logic                  wdata_valid_o,
  input  logic                  wdata_ready_i,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  wdata_last_o,
  output logic                  busy_o
);
  localparam int BW = $clog2(BURST_LEN);
  localparam int SW = $clog2(RD_STREAK_MAX + 1);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(BURST_LEN - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(RD_STREAK_MAX);

  typedef enum logic [1:0] {ARB, RD_CMD, WR_CMD, WR_DATA} state_t;

  state_t                r_state;
  logic                  r_cmd_valid;
  logic                  r_cmd_write;
  logic [ADDR_WIDTH-1:0] r_cmd_addr;
  logic [BW-1:0]         r_beat;
  logic [SW-1:0]         r_rd_streak;

  logic w_in_arb;
  logic w_in_data;
  logic w_wr_grant;
  logic w_rd_grant;
  logic w_beat_fire;

  assign w_in_arb    = (r_state == ARB);
  assign w_in_data   = (r_state == WR_DATA);
  assign w_wr_grant  = w_in_arb && wr_valid_i && (!rd_valid_i || (r_rd_streak == STREAK_MAX));
  assign w_rd_grant  = w_in_arb && rd_valid_i && !w_wr_grant;
  assign w_beat_fire = w_in_data && wr_valid_i && wdata_ready_i;

  // The writer's ready means "address beat taken" in ARB and "data beat taken" in WR_DATA.
  assign wr_ready_o    = w_wr_grant || (w_in_data && wdata_ready_i);
  assign rd_ready_o    = w_rd_grant;
  assign wdata_valid_o = w_in_data && wr_valid_i;
  assign wdata_o       = wr_data_i;
  assign wdata_last_o  = wdata_valid_o && (r_beat == LAST_BEAT);
  assign busy_o        = !w_in_arb;
  assign cmd_valid_o   = r_cmd_valid;
  assign cmd_write_o   = r_cmd_write;
  assign cmd_addr_o    = r_cmd_addr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ARB;
      r_cmd_valid <= 1'b0;
      r_cmd_write <= 1'b0;
      r_cmd_addr  <= '0;
      r_beat      <= '0;
      r_rd_streak <= '0;
    end else begin
      case (r_state)
        ARB: begin
          if (w_wr_grant) begin
            r_cmd_addr  <= wr_addr_i;
            r_cmd_write <= 1'b1;
            r_cmd_valid <= 1'b1;
            r_rd_streak <= '0;
            r_state     <= WR_CMD;
          end else if (w_rd_grant) begin
            r_cmd_addr  <= rd_addr_i;
            r_cmd_write <= 1'b0;
            r_cmd_valid <= 1'b1;
            r_state     <= RD_CMD;
            // The streak only counts reads that actually made a writer wait.
            if (!wr_valid_i) begin
              r_rd_streak <= '0;
            end else if (r_rd_streak != STREAK_MAX) begin
              r_rd_streak <= r_rd_streak + 1'b1;
            end
          end
        end
        RD_CMD: begin
          if (cmd_ready_i) begin
            r_cmd_valid <= 1'b0;
            r_state     <= ARB;
          end
        end
        WR_CMD: begin
          if (cmd_ready_i) begin
            r_cmd_valid <= 1'b0;
            r_beat      <= '0;
            r_state     <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (w_beat_fire) begin
            r_beat <= r_beat + 1'b1;
            if (r_beat == LAST_BEAT) begin
              r_state <= ARB;
            end
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed scenarios plus randomized traffic for sdram_port_arbiter, checked every cycle
// against a transaction-level model of the arbitration rules.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;
  localparam int AW  = 24;
  localparam int DW  = 16;
  localparam int BL  = 8;
  localparam int RSM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid, wr_ready, rd_valid, rd_ready;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic          wdata_valid, wdata_ready, wdata_last, busy;
  logic [AW-1:0] wr_addr, rd_addr, cmd_addr;
  logic [DW-1:0] wr_data, wdata;

  always #5 clk = ~clk;

  sdram_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .RD_STREAK_MAX(RSM)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_valid_i(rd_valid), .rd_ready_o(rd_ready), .rd_addr_i(rd_addr),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_write_o(cmd_write),
    .cmd_addr_o(cmd_addr),
    .wdata_valid_o(wdata_valid), .wdata_ready_i(wdata_ready), .wdata_o(wdata),
    .wdata_last_o(wdata_last), .busy_o(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit pct(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  // Requester/driver behaviour knobs (percent probabilities).
  int p_wnew, p_wvld, p_rd, p_crdy, p_drdy;

  bit            w_act, w_addr_done;
  int            w_idx;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data [BL];
  bit            r_act;
  logic [AW-1:0] r_addr;
  int            stall_at = -1;
  int            stall_left = 0;

  // Reference model: one outstanding command, and beats still owed by the writer.
  bit            m_pend, m_wr;
  logic [AW-1:0] m_addr;
  int            m_left, m_streak;

  bit g_log[$];
  int cnt_busy, cnt_last, cnt_beats, cnt_cmdv, cnt_rrdy, cnt_dgap, beats_at_rd;

  task automatic reset_counts();
    cnt_busy = 0; cnt_last = 0; cnt_beats = 0; cnt_cmdv = 0;
    cnt_rrdy = 0; cnt_dgap = 0; beats_at_rd = -1;
    g_log.delete();
  endtask

  task automatic start_wr(input logic [AW-1:0] a, input bit fixed);
    w_act = 1'b1; w_addr_done = 1'b0; w_idx = 0; w_addr = a;
    for (int i = 0; i < BL; i++) w_data[i] = fixed ? DW'(i + 1) : DW'($urandom);
  endtask

  task automatic start_rd(input logic [AW-1:0] a);
    r_act = 1'b1; r_addr = a;
  endtask

  task automatic step();
    bit idle, wg, rg, ewr, edv, wfire;
    if (!w_act && pct(p_wnew)) start_wr(AW'($urandom), 1'b0);
    if (!r_act && pct(p_rd)) start_rd(AW'($urandom));
    if (!w_act) wr_valid = 1'b0;
    else if (!w_addr_done) wr_valid = 1'b1;
    else if (w_idx == stall_at && stall_left > 0) begin
      wr_valid = 1'b0;
      stall_left--;
    end else wr_valid = pct(p_wvld);
    wr_addr     = w_addr;
    wr_data     = (w_act && w_addr_done) ? w_data[w_idx] : DW'($urandom);
    rd_valid    = r_act;
    rd_addr     = r_addr;
    cmd_ready   = pct(p_crdy);
    wdata_ready = pct(p_drdy);
    #2;

    idle = !m_pend && (m_left == 0);
    wg   = idle && wr_valid && (!rd_valid || m_streak == RSM);
    rg   = idle && rd_valid && !wg;
    ewr  = wg || (m_left > 0 && wdata_ready);
    edv  = (m_left > 0) && wr_valid;
    check("cmd_valid", cmd_valid, m_pend);
    check("rd_ready", rd_ready, rg);
    check("wr_ready", wr_ready, ewr);
    check("wdata_valid", wdata_valid, edv);
    check("wdata_last", wdata_last, edv && m_left == 1);
    check("busy", busy, !idle);
    if (m_pend) begin
      check("cmd_write", cmd_write, m_wr);
      check("cmd_addr", cmd_addr, m_addr);
    end
    if (edv) check("wdata", wdata, w_data[BL - m_left]);

    if (busy) cnt_busy++;
    if (wdata_last) cnt_last++;
    if (wdata_valid && wdata_ready) cnt_beats++;
    if (cmd_valid) cnt_cmdv++;
    if (busy && !cmd_valid && !wdata_valid) cnt_dgap++;
    if (rd_ready) begin
      cnt_rrdy++;
      g_log.push_back(1'b0);
      if (beats_at_rd < 0) beats_at_rd = cnt_beats;
    end
    if (wr_ready && !busy) g_log.push_back(1'b1);

    if (rst) begin
      m_pend = 1'b0; m_wr = 1'b0; m_left = 0; m_streak = 0;
      w_act = 1'b0; r_act = 1'b0;
    end else begin
      wfire = (m_left > 0) && wr_valid && wdata_ready;
      if (m_pend && cmd_ready) begin
        m_pend = 1'b0;
        if (m_wr) m_left = BL;
      end
      if (wfire) begin
        m_left--;
        w_idx++;
        if (m_left == 0) w_act = 1'b0;
      end
      if (wg) begin
        m_pend = 1'b1; m_wr = 1'b1; m_addr = wr_addr; m_streak = 0; w_addr_done = 1'b1;
      end
      if (rg) begin
        m_pend = 1'b1; m_wr = 1'b0; m_addr = rd_addr; r_act = 1'b0;
        m_streak = wr_valid ? ((m_streak < RSM) ? m_streak + 1 : RSM) : 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    p_wnew = 0; p_rd = 0; p_wvld = 100; p_crdy = 100; p_drdy = 100;
    stall_at = -1; stall_left = 0;
    repeat (40) step();
  endtask

  initial begin
    rst = 1'b1;
    wr_valid = 1'b0; rd_valid = 1'b0; cmd_ready = 1'b0; wdata_ready = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    p_wnew = 0; p_wvld = 0; p_rd = 0; p_crdy = 0; p_drdy = 0;
    w_act = 1'b0; w_addr_done = 1'b0; w_idx = 0; w_addr = '0; r_act = 1'b0; r_addr = '0;
    m_pend = 1'b0; m_wr = 1'b0; m_addr = '0; m_left = 0; m_streak = 0;
    reset_counts();
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_write", cmd_write, 0);
    check("rst_cmd_addr", cmd_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_ready", rd_ready, 0);
    check("rst_wdata_valid", wdata_valid, 0);
    check("rst_wdata_last", wdata_last, 0);
    step();
    rst = 1'b0;

    // Lone write burst with data 1..8.
    p_crdy = 100; p_drdy = 100; p_wvld = 100;
    reset_counts();
    start_wr(24'h000040, 1'b1);
    repeat (14) step();
    check("wo_busy_cycles", cnt_busy, 9);
    check("wo_last_count", cnt_last, 1);
    check("wo_beats", cnt_beats, 8);

    // Lone read with the driver stalling three cycles.
    reset_counts();
    p_crdy = 0;
    start_rd(24'h080320);
    step();
    repeat (3) step();
    p_crdy = 100;
    repeat (4) step();
    check("ro_cmd_hold", cnt_cmdv, 4);
    check("ro_rd_pulses", cnt_rrdy, 1);

    // Both requesters saturated: R,R,R,R,W repeating.
    reset_counts();
    p_wnew = 100; p_rd = 100;
    for (int i = 0; i < 400 && g_log.size() < 15; i++) step();
    check("sat_grant_count", g_log.size() >= 15, 1);
    for (int i = 0; i < 15 && i < g_log.size(); i++)
      check($sformatf("sat_grant%0d", i), g_log[i], (i % 5) == 4);
    drain();

    // Writer stalls 5 cycles after 3 beats while a read waits.
    reset_counts();
    start_wr(24'h000100, 1'b1);
    stall_at = 3; stall_left = 5;
    step();
    p_rd = 100;
    for (int i = 0; i < 60 && cnt_beats < 8; i++) step();
    repeat (3) step();
    check("stall_beats", cnt_beats, 8);
    check("stall_gap", cnt_dgap, 5);
    check("stall_first_rd", beats_at_rd, 8);
    drain();

    // Reset in the middle of a write burst, then a clean burst.
    reset_counts();
    start_wr(24'h000200, 1'b1);
    for (int i = 0; i < 30 && !(w_addr_done && w_idx == 4); i++) step();
    check("mid_rst_reached", w_idx, 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cmd_valid", cmd_valid, 0);
    check("mid_rst_wdata_valid", wdata_valid, 0);
    reset_counts();
    start_wr(24'h000300, 1'b1);
    repeat (14) step();
    check("post_rst_beats", cnt_beats, 8);
    check("post_rst_last", cnt_last, 1);

    // Reads with no writer waiting leave the streak at zero.
    drain();
    reset_counts();
    p_rd = 100;
    repeat (6) step();
    check("idle_reads", g_log.size(), 3);
    g_log.delete();
    start_wr(24'h000400, 1'b1);
    for (int i = 0; i < 100 && !(g_log.size() > 0 && g_log[g_log.size()-1]); i++) step();
    check("streak_wr_pos", g_log.size(), 5);

    // Randomized traffic with occasional resets.
    drain();
    p_wnew = 30; p_rd = 40; p_wvld = 70; p_crdy = 60; p_drdy = 70;
    repeat (3000) begin
      rst = ($urandom_range(299) == 0);
      step();
    end
    rst = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM driver command/write-data channel between the framebuffer fill writer (address beat followed by BURST_LEN data beats) and the display line prefetch reader (one address beat per burst).
- Reads have priority to protect the display from underflow.
- A streak limit guarantees that a waiting writer gets one burst after RD_STREAK_MAX consecutive read grants.
- Sits between the framebuffer controller's writer/reader ports and the SDRAM driver.

Parameters:
- ADDR_WIDTH, 24, SDRAM word address width.
- DATA_WIDTH, 16, pixel/data word width.
- BURST_LEN, 8, data beats per write burst (power of two, ≥2).
- RD_STREAK_MAX, 4, consecutive read grants allowed while a write is pending (≥1).

Ports:
- clk_i  in  1  system clock, single domain.
- rst_i  in  1  synchronous, active-high reset.
- wr_valid_i  in  1  writer valid (address beat, then data beats).
- wr_ready_o  out  1  writer ready.
- wr_addr_i  in  ADDR_WIDTH  write burst start address, sampled on the address beat.
- wr_data_i  in  DATA_WIDTH  write data, used on data beats.
- rd_valid_i  in  1  reader burst request valid.
- rd_ready_o  out  1  reader request accepted.
- rd_addr_i  in  ADDR_WIDTH  read burst start address.
- cmd_valid_o  out  1  command to SDRAM driver valid.
- cmd_ready_i  in  1  driver accepts command.
- cmd_write_o  out  1  1 = write burst, 0 = read burst.
- cmd_addr_o  out  ADDR_WIDTH  burst start address.
- wdata_valid_o  out  1  write data valid.
- wdata_ready_i  in  1  driver accepts write data.
- wdata_o  out  DATA_WIDTH  write data.
- wdata_last_o  out  1  final beat of a write burst.
- busy_o  out  1  arbiter not in ARB state.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: state = ARB; cmd_valid_o, cmd_write_o, cmd_addr_o, beat counter and rd_streak all 0. In ARB with no requests, wr_ready_o, rd_ready_o, wdata_valid_o, wdata_last_o and busy_o are all 0.
- States: ARB, RD_CMD, WR_CMD, WR_DATA.
- ARB decision (combinational, evaluated every cycle in ARB):
  - Grant write if wr_valid_i && (!rd_valid_i || rd_streak == RD_STREAK_MAX).
  - Otherwise grant read if rd_valid_i.
  - Otherwise no grant.
- Read grant:
  - rd_ready_o = 1 this cycle.
  - Next edge: cmd_addr_o <= rd_addr_i, cmd_write_o <= 0, cmd_valid_o <= 1, go to RD_CMD.
  - rd_streak <= rd_streak+1 if wr_valid_i, else 0. Saturates at RD_STREAK_MAX.
- Write grant:
  - wr_ready_o = 1 this cycle; this is the writer's address beat.
  - Next edge: cmd_addr_o <= wr_addr_i, cmd_write_o <= 1, cmd_valid_o <= 1, rd_streak <= 0, go to WR_CMD.
- Only one of rd_ready_o / wr_ready_o is high in any cycle.
- RD_CMD: hold cmd_valid_o and cmd_addr_o stable until cmd_ready_i. On handshake: cmd_valid_o <= 0, go to ARB.
- WR_CMD: same hold rule. On handshake: cmd_valid_o <= 0, beat counter <= 0, go to WR_DATA.
- WR_DATA (combinational pass-through):
  - wdata_valid_o = wr_valid_i; wr_ready_o = wdata_ready_i; wdata_o = wr_data_i.
  - wdata_last_o = wdata_valid_o && (beat == BURST_LEN-1).
  - Beat counter increments on each wr_valid_i && wdata_ready_i.
  - After the handshake on beat BURST_LEN-1: go to ARB.
  - Writer stalls (wr_valid_i low) are tolerated indefinitely; no timeout.
- Latency:
  - Request in ARB to cmd_valid_o high: 1 cycle.
  - Minimum read burst period: 2 cycles (ARB, RD_CMD) with cmd_ready_i held high.
  - Minimum write burst: 2 + BURST_LEN cycles.
- Simultaneous requests: read wins unless rd_streak == RD_STREAK_MAX.
- Idle writer: rd_streak is cleared on any read grant made with wr_valid_i low.
- No arbitration inside a burst: rd_valid_i is ignored (rd_ready_o = 0) outside ARB.
- Addresses pass through unmodified; alignment is the requester's responsibility.
- Reset mid-burst: state returns to ARB and all outputs take reset values on the next edge. The partial burst is abandoned; the driver is reset alongside.
- busy_o = (state != ARB).

Test Plan:
- Write only (cmd_ready_i, wdata_ready_i = 1), wr_addr_i = 0x000040, data 1..8 → cmd_write_o = 1, cmd_addr_o = 0x000040 on the cycle after the address beat; 8 wdata beats; wdata_last_o only on data 8; back in ARB after 10 cycles.
- Read only, rd_addr_i = 0x080320, cmd_ready_i low for 3 cycles → cmd_valid_o and cmd_addr_o = 0x080320 held 4 cycles; rd_ready_o pulses exactly once.
- rd_valid_i and wr_valid_i both continuously high, RD_STREAK_MAX = 4 → grant sequence R,R,R,R,W,R,R,R,R,W…; cmd_write_o pattern matches.
- Writer drops wr_valid_i for 5 cycles mid-burst (after beat 3), rd_valid_i high → wdata_valid_o low for those cycles; no read granted until beat 8 completes; total 8 data beats.
- rst_i asserted during WR_DATA beat 4 → next cycle state ARB, cmd_valid_o = 0, wdata_valid_o = 0, busy_o = 0; the following write burst restarts at beat 0.
- Reads granted with wr_valid_i low, then a write arrives → rd_streak is 0, so 4 further reads precede the write grant.
